// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: two-flop synchroniser, mid-bit sampling FSM, framing-error and glitch
// rejection. Define UART_RX_MAJORITY_EN to take a 2-of-3 majority vote at every sample point.
module uart_receiver #(
  parameter int unsigned SYS_PERIOD      = 100_000_000,
  parameter int unsigned BPS             = 115_200,
  parameter int unsigned BIT_PERIOD      = SYS_PERIOD / BPS,
  parameter int unsigned HALF_BIT_PERIOD = BIT_PERIOD / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] data_receive,
  output logic       receive_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [14:0] BitLast  = 15'(BIT_PERIOD - 1);
  localparam logic [14:0] HalfLast = 15'(HALF_BIT_PERIOD - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBrk} state_e;

  state_e      state_q, state_d;
  logic [1:0]  sync_q;
  logic [14:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic        rx_s;
  logic        sample_bit;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rxd};
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0]  vote_q;
  logic [14:0] cnt_last;
  logic        counting;

  assign cnt_last = (state_q == StStart) ? HalfLast : BitLast;
  assign counting = (state_q == StStart) || (state_q == StData) || (state_q == StStop);

  // Early votes at P-3 and P-2; the live rx_s supplies the third vote at P-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_q <= 2'b11;
    end else if (counting) begin
      if (cnt_q == cnt_last - 15'd2) vote_q[0] <= rx_s;
      if (cnt_q == cnt_last - 15'd1) vote_q[1] <= rx_s;
    end
  end

  assign sample_bit = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
  assign sample_bit = rx_s;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 15'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (!sample_bit) begin
            state_d = StData;
            idx_d   = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d          = '0;
          shift_d[idx_q] = sample_bit;
          if (idx_q == 3'd7) state_d = StStop;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      StStop: begin
        // Leaving at mid stop bit lets a start edge right after it be caught.
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (sample_bit) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBrk;
          end
        end
      end
      StBrk: begin
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_receive = data_q;
  assign receive_done = done_q;
  assign frame_err    = ferr_q;
  assign rx_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit; expected bytes and timings hand-derived.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic [7:0] data_receive;
  logic       receive_done;
  logic       frame_err;
  logic       rx_busy;

  uart_receiver #(
    .SYS_PERIOD(1_600_000),
    .BPS       (100_000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rxd    (uart_rxd),
    .data_receive(data_receive),
    .receive_done(receive_done),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled on the falling edge.
  int   done_cnt = 0;
  int   ferr_cnt = 0;
  int   busy_cnt = 0;
  int   both_cnt = 0;
  int   wide_cnt = 0;
  logic prev_done = 1'b0;
  logic prev_ferr = 1'b0;
  int   done_cyc[$];
  logic [7:0] done_dat[$];

  always @(negedge clk) begin
    if (receive_done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      done_dat.push_back(data_receive);
    end
    if (frame_err) ferr_cnt++;
    if (rx_busy) busy_cnt++;
    if (receive_done && frame_err) both_cnt++;
    if ((receive_done && prev_done) || (frame_err && prev_ferr)) wide_cnt++;
    prev_done = receive_done;
    prev_ferr = frame_err;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bit time; optionally invert the line for one cycle at offset goff.
  task automatic drive_bit(input logic v, input int goff);
    for (int k = 0; k < 16; k++) begin
      uart_rxd = (k == goff) ? ~v : v;
      tick(1);
    end
  endtask

  // gbit is the bit position (0 start, 1..8 data, 9 stop) carrying the glitch; -1 for none.
  task automatic send(input logic [7:0] b, input logic stop, input int gbit, input int goff,
                      output int fall);
    fall = cyc;
    drive_bit(1'b0, (gbit == 0) ? goff : -1);
    for (int i = 0; i < 8; i++) drive_bit(b[i], (gbit == i + 1) ? goff : -1);
    drive_bit(stop, (gbit == 9) ? goff : -1);
  endtask

  int f, lat, d0, e0, b0, n;

  initial begin
    tick(3);
    check_eq("rst_data", {24'd0, data_receive}, 32'h00);
    check_eq("rst_done", {31'd0, receive_done}, 32'd0);
    check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
    check_eq("rst_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b0;
    tick(10);

    // 1: single frame, latency 8 + 9*16 + 3 = 155
    d0 = done_cnt; e0 = ferr_cnt;
    send(8'hA5, 1'b1, -1, -1, f);
    tick(5);
    check_eq("t1_done_cnt", done_cnt - d0, 1);
    check_eq("t1_ferr_cnt", ferr_cnt - e0, 0);
    check_eq("t1_data", {24'd0, data_receive}, 32'hA5);
    lat = (done_cyc.size() > 0) ? done_cyc[done_cyc.size() - 1] - f : -1;
    check_eq("t1_latency_155pm1", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);

    // 2: back-to-back frames
    d0 = done_cnt; n = done_cyc.size();
    send(8'h00, 1'b1, -1, -1, f);
    send(8'hFF, 1'b1, -1, -1, f);
    send(8'h3C, 1'b1, -1, -1, f);
    tick(5);
    check_eq("t2_done_cnt", done_cnt - d0, 3);
    if (done_cyc.size() >= n + 3) begin
      check_eq("t2_gap01", done_cyc[n + 1] - done_cyc[n], 160);
      check_eq("t2_gap12", done_cyc[n + 2] - done_cyc[n + 1], 160);
      check_eq("t2_b0", {24'd0, done_dat[n]}, 32'h00);
      check_eq("t2_b1", {24'd0, done_dat[n + 1]}, 32'hFF);
      check_eq("t2_b2", {24'd0, done_dat[n + 2]}, 32'h3C);
    end

    // 3: framing error, held break, recovery
    d0 = done_cnt; e0 = ferr_cnt;
    send(8'h55, 1'b0, -1, -1, f);
    uart_rxd = 1'b0;
    tick(50);
    uart_rxd = 1'b1;
    tick(20);
    check_eq("t3_ferr_cnt", ferr_cnt - e0, 1);
    check_eq("t3_no_done", done_cnt - d0, 0);
    check_eq("t3_data_held", {24'd0, data_receive}, 32'h3C);
    send(8'h81, 1'b1, -1, -1, f);
    tick(5);
    check_eq("t3_next_done", done_cnt - d0, 1);
    check_eq("t3_next_data", {24'd0, data_receive}, 32'h81);

    // 4: 4-clock glitch on idle line
    d0 = done_cnt; e0 = ferr_cnt; b0 = busy_cnt;
    uart_rxd = 1'b0;
    tick(4);
    uart_rxd = 1'b1;
    tick(30);
    check_eq("t4_busy_seen", {31'd0, (busy_cnt - b0 > 0)}, 32'd1);
    check_eq("t4_busy_le12", {31'd0, (busy_cnt - b0 <= 12)}, 32'd1);
    check_eq("t4_no_done", done_cnt - d0, 0);
    check_eq("t4_no_ferr", ferr_cnt - e0, 0);
    check_eq("t4_idle", {31'd0, rx_busy}, 32'd0);

    // 5: reset inside data bit 4 of 8'hC3
    d0 = done_cnt; e0 = ferr_cnt;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(((8'hC3 >> i) & 8'h01) != 8'h00, -1);
    uart_rxd = 1'b0;
    tick(4);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_data", {24'd0, data_receive}, 32'h00);
    check_eq("t5_rst_busy", {31'd0, rx_busy}, 32'd0);
    check_eq("t5_rst_done", {31'd0, receive_done}, 32'd0);
    uart_rxd = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(30);
    check_eq("t5_no_pulse", (done_cnt - d0) + (ferr_cnt - e0), 0);
    send(8'h7E, 1'b1, -1, -1, f);
    tick(5);
    check_eq("t5_next_done", done_cnt - d0, 1);
    check_eq("t5_next_data", {24'd0, data_receive}, 32'h7E);

    // 6: one-cycle glitch in data bit 2 of 8'h0F
    d0 = done_cnt;
`ifdef UART_RX_MAJORITY_EN
    send(8'h0F, 1'b1, 3, 7, f);
    tick(5);
    check_eq("t6_maj_data", {24'd0, data_receive}, 32'h0F);
`else
    send(8'h0F, 1'b1, 3, 8, f);
    tick(5);
    check_eq("t6_single_data", {24'd0, data_receive}, 32'h0B);
`endif
    check_eq("t6_done", done_cnt - d0, 1);

    check_eq("never_both", both_cnt, 0);
    check_eq("pulse_width_1", wide_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receive stage. It sits directly upstream of the UART transmitter and feeds it.
- Deserialises 8N1 frames arriving on uart_rxd.
- Presents each byte on data_receive with a one-cycle receive_done strobe, the exact handshake the transmitter consumes.
- Flags bad stop bits and filters glitches shorter than half a bit.

Parameters:
SYS_PERIOD, 100_000_000, system clock frequency in Hz
BPS, 115_200, baud rate
BIT_PERIOD, SYS_PERIOD/BPS, clocks per bit (derived; 868 at defaults)
HALF_BIT_PERIOD, BIT_PERIOD/2, clocks per half bit (derived; 434 at defaults; must be >= 4)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high; clears all state immediately on assertion
uart_rxd  input  1  serial line, asynchronous to clk, idle high
data_receive  output  8  last correctly framed byte, LSB received first
receive_done  output  1  one-cycle pulse: data_receive valid/updated this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled low
rx_busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset values: data_receive=8'h00, receive_done=0, frame_err=0, rx_busy=0. Synchroniser flops = 1. FSM=IDLE, counters=0.
- Synchroniser: uart_rxd passes through 2 flops to give rx_s; only rx_s is used downstream.
- Bit counter cnt: 15 bits. Cleared on every state transition. Increments by 1 each cycle in START/DATA/STOP.
- Bit index idx: 3 bits.
- FSM:
  - IDLE: rx_s==0 -> START.
  - START: at cnt==HALF_BIT_PERIOD-1, sample rx_s. If 0 -> DATA with idx=0. If 1 (false start/glitch) -> IDLE, no outputs pulsed.
  - DATA: at cnt==BIT_PERIOD-1, sample rx_s into shift[idx]. idx<7 -> idx+1, stay in DATA. idx==7 -> STOP.
  - STOP: at cnt==BIT_PERIOD-1, sample rx_s.
    - If 1: data_receive<=shift and receive_done<=1 (registered, same cycle) -> IDLE.
    - If 0: frame_err<=1, data_receive unchanged -> BRK.
  - BRK: wait for rx_s==1 -> IDLE. Prevents a held-low line (break) from being re-read as a new start.
- Sample points are mid-bit. At defaults, each data sample falls BIT_PERIOD after the previous one, first at 1.5 bits after the start edge.
- Latency: receive_done rises HALF_BIT_PERIOD+9*BIT_PERIOD+3 clocks (±1) after the uart_rxd falling edge.
- Back-to-back frames: IDLE is re-entered mid stop bit, so a start edge immediately after the stop bit is caught with no lost frame.
- receive_done and frame_err are never high together. Each is high for exactly 1 cycle per frame.
- data_receive holds its value between frames and after framing errors.
- Reset mid-frame: all state clears asynchronously and no pulse is emitted. After release, the FSM resynchronises on the next falling edge of rx_s. A partial frame in flight may be misread; this is accepted.
- The transmitter downstream runs for 10 bit times per byte, so the receiver imposes no flow control. Bytes are produced at most once per frame time.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each sample point uses a 2-of-3 majority of rx_s.
  - Votes are taken at cnt==P-3, P-2 and P-1, where P is HALF_BIT_PERIOD or BIT_PERIOD.
  - The decision is made at cnt==P-1, so latency is unchanged.
  - A single-cycle glitch at a sample point is rejected.
- Undefined: single sample of rx_s at cnt==P-1, and the voting flops are not built.

Test Plan:
Bench parameters for all scenarios: SYS_PERIOD=1_600_000 and BPS=100_000, giving BIT_PERIOD=16 and HALF_BIT_PERIOD=8.
1. Drive frame for byte 8'hA5 (start, 1,0,1,0,0,1,0,1, stop) -> receive_done 1 cycle, data_receive=8'hA5, frame_err=0, pulse at 155±1 clocks after edge.
2. Drive frames 8'h00, 8'hFF, 8'h3C back-to-back with no idle gap -> three receive_done pulses exactly 160 clocks apart, with values 00, FF, 3C.
3. Frame 8'h55 with stop bit driven 0, then line held low 50 clocks, then high, then frame 8'h81 -> frame_err pulse, data_receive stays at prior value, no receive_done for 55. Next frame yields 8'h81.
4. Low glitch of 4 clocks on idle line -> FSM returns to IDLE, no receive_done or frame_err, rx_busy high for <=12 clocks.
5. Assert rst at data bit 4 of frame 8'hC3 for 3 cycles -> outputs at reset values immediately, no pulse. A following clean frame 8'h7E is received correctly.
6. UART_RX_MAJORITY_EN defined: frame 8'h0F with a 1-cycle inverted glitch at cnt==BIT_PERIOD-2 of bit 2 -> data_receive=8'h0F. Undefined: same glitch at cnt==BIT_PERIOD-1 -> data_receive=8'h0B.
